// File: rtl/axi4_rdata_unpacker.sv
// DDR3 read-data FIFO and 128->64 bit AXI4 R-channel beat generator.
// Define AXI_RD_SKID_EN to drive the R channel from a 2-entry registered skid buffer.
module axi4_rdata_unpacker #(
    parameter int FIFO_DEPTH = 16,
    parameter int ID_W       = 4,
    parameter int CNT_W      = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             rd_start,
    output logic             rd_ready,
    input  logic [ID_W-1:0]  rd_id,
    input  logic [7:0]       rd_len,
    input  logic             rd_half,
    input  logic             app_rdata_valid,
    input  logic [127:0]     app_rdata,
    output logic [CNT_W-1:0] fifo_free,
    output logic             ovf_err,
    output logic             io_axi4_rvalid,
    input  logic             io_axi4_rready,
    output logic [ID_W-1:0]  io_axi4_rid,
    output logic [63:0]      io_axi4_rdata,
    output logic [1:0]       io_axi4_rresp,
    output logic             io_axi4_rlast
);
    // state  | meaning
    // IDLE   | waiting for a burst descriptor, rd_ready high
    // STREAM | emitting beats of the latched burst from the FIFO head

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t           state;
    logic [127:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count, count_nxt;
    logic             full_q, empty, push, pop;
    logic [ID_W-1:0]  id_q;
    logic [7:0]       remaining;
    logic             half;
    logic             beat_valid, beat_fire, beat_last;
    logic [63:0]      beat_data;

    assign empty      = (count == '0);
    assign push       = app_rdata_valid && !full_q;
    assign beat_valid = (state == STREAM) && !empty;
    assign beat_last  = (remaining == 8'd0);
    assign beat_data  = half ? mem[rd_ptr][127:64] : mem[rd_ptr][63:0];
    // A word leaves after its upper half, or early when the burst ends on its lower half.
    assign pop        = beat_fire && (half || beat_last);
    assign count_nxt  = count + CNT_W'(push) - CNT_W'(pop);
    assign io_axi4_rresp = 2'b00;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= app_rdata;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            full_q    <= 1'b0;
            fifo_free <= CNT_W'(FIFO_DEPTH);
            ovf_err   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count     <= count_nxt;
            full_q    <= (count_nxt == CNT_W'(FIFO_DEPTH));
            fifo_free <= CNT_W'(FIFO_DEPTH) - count_nxt;
            if (app_rdata_valid && full_q) ovf_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            rd_ready  <= 1'b1;
            id_q      <= '0;
            remaining <= '0;
            half      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rd_start) begin
                        state     <= STREAM;
                        rd_ready  <= 1'b0;
                        id_q      <= rd_id;
                        remaining <= rd_len;
                        half      <= rd_half;
                    end
                end
                STREAM: begin
                    if (beat_fire) begin
                        half      <= ~half;
                        remaining <= remaining - 8'd1;
                        if (beat_last) begin
                            state    <= IDLE;
                            rd_ready <= 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    rd_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef AXI_RD_SKID_EN
    localparam int SW = ID_W + 1 + 64;

    logic [SW-1:0] skid0, skid1, skid_new;
    logic [1:0]    skid_cnt;
    logic          skid_deq;

    // The engine only looks at skid occupancy, so rready never reaches FIFO/FSM logic.
    assign beat_fire = beat_valid && (skid_cnt != 2'd2);
    assign skid_deq  = (skid_cnt != 2'd0) && io_axi4_rready;
    assign skid_new  = {id_q, beat_last, beat_data};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            skid0    <= '0;
            skid1    <= '0;
            skid_cnt <= '0;
        end else begin
            case ({beat_fire, skid_deq})
                2'b10: begin
                    if (skid_cnt == 2'd0) skid0 <= skid_new;
                    else                  skid1 <= skid_new;
                    skid_cnt <= skid_cnt + 2'd1;
                end
                2'b01: begin
                    skid0    <= skid1;
                    skid_cnt <= skid_cnt - 2'd1;
                end
                2'b11: skid0 <= skid_new;
                default: ;
            endcase
        end
    end

    assign io_axi4_rvalid = (skid_cnt != 2'd0);
    assign {io_axi4_rid, io_axi4_rlast, io_axi4_rdata} = skid0;
`else
    assign beat_fire      = beat_valid && io_axi4_rready;
    assign io_axi4_rvalid = beat_valid;
    assign io_axi4_rid    = id_q;
    assign io_axi4_rdata  = beat_valid ? beat_data : 64'd0;
    assign io_axi4_rlast  = beat_valid && beat_last;
`endif

endmodule

// File: tb/tb_axi4_rdata_unpacker.sv
// Randomized self-checking bench for axi4_rdata_unpacker against a word-queue reference model.
module tb_axi4_rdata_unpacker;
    localparam int DEPTH = 16;
`ifdef AXI_RD_SKID_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic         clk = 1'b0;
    logic         rstn;
    logic         rd_start, rd_ready, rd_half;
    logic [3:0]   rd_id;
    logic [7:0]   rd_len;
    logic         app_rdata_valid;
    logic [127:0] app_rdata;
    logic [4:0]   fifo_free;
    logic         ovf_err;
    logic         io_axi4_rvalid, io_axi4_rready, io_axi4_rlast;
    logic [3:0]   io_axi4_rid;
    logic [63:0]  io_axi4_rdata;
    logic [1:0]   io_axi4_rresp;

    axi4_rdata_unpacker dut (
        .clk(clk), .rstn(rstn),
        .rd_start(rd_start), .rd_ready(rd_ready), .rd_id(rd_id), .rd_len(rd_len), .rd_half(rd_half),
        .app_rdata_valid(app_rdata_valid), .app_rdata(app_rdata),
        .fifo_free(fifo_free), .ovf_err(ovf_err),
        .io_axi4_rvalid(io_axi4_rvalid), .io_axi4_rready(io_axi4_rready), .io_axi4_rid(io_axi4_rid),
        .io_axi4_rdata(io_axi4_rdata), .io_axi4_rresp(io_axi4_rresp), .io_axi4_rlast(io_axi4_rlast)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        last;
        logic [3:0]  id;
        logic [63:0] data;
    } beat_t;

    beat_t        got_q[$];
    beat_t        exp_q[$];
    logic [127:0] words_q[$];
    int           checks = 0;
    int           errors = 0;

    // rready is changed only just after posedge, so a negedge sample sees the beat that fires next edge.
    always @(negedge clk)
        if (rstn && io_axi4_rvalid && io_axi4_rready)
            got_q.push_back({io_axi4_rlast, io_axi4_rid, io_axi4_rdata});

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic push_word(input logic [127:0] w);
        app_rdata_valid = 1'b1;
        app_rdata       = w;
        tick();
        app_rdata_valid = 1'b0;
        if (words_q.size() < DEPTH) words_q.push_back(w);
    endtask

    task automatic start_burst(input logic [3:0] id, input logic [7:0] len, input logic half);
        int n = 0;
        while (!rd_ready && n < 300) begin
            tick();
            n++;
        end
        rd_id    = id;
        rd_len   = len;
        rd_half  = half;
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
    endtask

    task automatic wait_beats(input int n, output bit ok);
        int c = 0;
        while (got_q.size() < n && c < 600) begin
            tick();
            c++;
        end
        ok = (got_q.size() >= n);
    endtask

    // Reference: beat i of a burst reads half (rd_half+i)%2 of word (rd_half+i)/2.
    task automatic model_burst(input logic [3:0] id, input logic [7:0] len, input logic half);
        int nw = (int'(half) + int'(len)) / 2 + 1;
        for (int i = 0; i <= int'(len); i++) begin
            int k = int'(half) + i;
            logic [127:0] w = words_q[k / 2];
            exp_q.push_back({(i == int'(len)), id, ((k % 2) == 1) ? w[127:64] : w[63:0]});
        end
        repeat (nw) void'(words_q.pop_front());
    endtask

    task automatic test_reset();
        rstn = 1'b0; rd_start = 1'b0; rd_id = '0; rd_len = '0; rd_half = 1'b0;
        app_rdata_valid = 1'b0; app_rdata = '0; io_axi4_rready = 1'b0;
        tick(); tick();
        checks++; if (io_axi4_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b exp 0", io_axi4_rvalid); end
        checks++; if (io_axi4_rlast !== 1'b0) begin errors++; $display("FAIL reset_rlast got %b exp 0", io_axi4_rlast); end
        checks++; if ({io_axi4_rid, io_axi4_rdata, io_axi4_rresp} !== 70'd0) begin errors++; $display("FAIL reset_rid_rdata got %h %h %h exp 0", io_axi4_rid, io_axi4_rdata, io_axi4_rresp); end
        checks++; if (rd_ready !== 1'b1) begin errors++; $display("FAIL reset_rd_ready got %b exp 1", rd_ready); end
        checks++; if (fifo_free !== 5'd16) begin errors++; $display("FAIL reset_fifo_free got %0d exp 16", fifo_free); end
        checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", ovf_err); end
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        bit ok;
        io_axi4_rready = 1'b1;
        start_burst(4'h5, 8'd3, 1'b0);
        push_word(rand_word());
        push_word(rand_word());
        wait_beats(4, ok);
        tick();
        model_burst(4'h5, 8'd3, 1'b0);
        checks++; if (!ok || got_q.size() != 4) begin errors++; $display("FAIL basic_count got %0d exp 4", got_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_beat%0d got %h exp %h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (fifo_free !== 5'd16) begin errors++; $display("FAIL basic_free got %0d exp 16", fifo_free); end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_single_upper();
        bit ok;
        io_axi4_rready = 1'b1;
        push_word(rand_word());
        start_burst(4'h2, 8'd0, 1'b1);
        wait_beats(1, ok);
        checks++; if (rd_ready !== 1'b1) begin errors++; $display("FAIL single_rd_ready got %b exp 1", rd_ready); end
        checks++; if (fifo_free !== 5'd16) begin errors++; $display("FAIL single_free got %0d exp 16", fifo_free); end
        model_burst(4'h2, 8'd0, 1'b1);
        checks++; if (!ok || got_q.size() != 1 || got_q[0] !== exp_q[0]) begin errors++; $display("FAIL single_beat got %h exp %h", got_q[0], exp_q[0]); end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_len2_discard();
        bit ok;
        io_axi4_rready = 1'b1;
        start_burst(4'h7, 8'd2, 1'b0);
        push_word(rand_word());
        push_word(rand_word());
        push_word(rand_word());
        wait_beats(3, ok);
        start_burst(4'h8, 8'd0, 1'b0);
        wait_beats(4, ok);
        tick();
        model_burst(4'h7, 8'd2, 1'b0);
        model_burst(4'h8, 8'd0, 1'b0);
        checks++; if (!ok || got_q.size() != 4) begin errors++; $display("FAIL len2_count got %0d exp 4", got_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin errors++; $display("FAIL len2_beat%0d got %h exp %h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (fifo_free !== 5'd16) begin errors++; $display("FAIL len2_free got %0d exp 16", fifo_free); end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_idle_buffer();
        bit ok;
        io_axi4_rready = 1'b1;
        push_word(rand_word());
        tick(); tick(); tick();
        checks++; if (fifo_free !== 5'd15) begin errors++; $display("FAIL idle_free got %0d exp 15", fifo_free); end
        checks++; if (io_axi4_rvalid !== 1'b0) begin errors++; $display("FAIL idle_rvalid got %b exp 0", io_axi4_rvalid); end
        start_burst(4'hA, 8'd1, 1'b0);
        wait_beats(2, ok);
        model_burst(4'hA, 8'd1, 1'b0);
        checks++; if (!ok || got_q.size() != 2) begin errors++; $display("FAIL idle_count got %0d exp 2", got_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin errors++; $display("FAIL idle_beat%0d got %h exp %h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_latency();
        bit ok;
        int lat = 0;
        io_axi4_rready = 1'b0;
        start_burst(4'h3, 8'd1, 1'b0);
        tick(); tick();
        checks++; if (io_axi4_rvalid !== 1'b0) begin errors++; $display("FAIL lat_empty_rvalid got %b exp 0", io_axi4_rvalid); end
        push_word(rand_word());
        while (!io_axi4_rvalid && lat < 5) begin
            tick();
            lat++;
        end
        checks++; if (lat + 1 != LAT) begin errors++; $display("FAIL latency got %0d exp %0d", lat + 1, LAT); end
        io_axi4_rready = 1'b1;
        wait_beats(2, ok);
        model_burst(4'h3, 8'd1, 1'b0);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (!ok || got_q[i] !== exp_q[i]) begin errors++; $display("FAIL lat_beat%0d got %h exp %h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_random();
        int total = 0;
        for (int b = 0; b < 25; b++) begin
            logic [3:0] id   = 4'($urandom);
            logic [7:0] len  = 8'($urandom_range(0, 7));
            logic       half = 1'($urandom);
            int         nw   = (int'(half) + int'(len)) / 2 + 1;
            total += int'(len) + 1;
            start_burst(id, len, half);
            fork
                begin
                    for (int w = 0; w < nw; w++) begin
                        repeat ($urandom_range(0, 2)) tick();
                        push_word(rand_word());
                    end
                end
                begin
                    int c = 0;
                    while (got_q.size() < total && c < 400) begin
                        io_axi4_rready = 1'($urandom);
                        tick();
                        c++;
                    end
                end
            join
            model_burst(id, len, half);
        end
        io_axi4_rready = 1'b0;
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_beat%0d got %h exp %h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_overflow();
        bit ok;
        io_axi4_rready = 1'b0;
        for (int i = 0; i < 16; i++) push_word(rand_word());
        checks++; if (fifo_free !== 5'd0) begin errors++; $display("FAIL ovf_free got %0d exp 0", fifo_free); end
        checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL ovf_early got %b exp 0", ovf_err); end
        push_word(rand_word());
        checks++; if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", ovf_err); end
        repeat (3) tick();
        start_burst(4'h3, 8'd31, 1'b0);
        io_axi4_rready = 1'b1;
        wait_beats(32, ok);
        tick();
        model_burst(4'h3, 8'd31, 1'b0);
        checks++; if (!ok || got_q.size() != 32) begin errors++; $display("FAIL ovf_count got %0d exp 32", got_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_beat%0d got %h exp %h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (ovf_err !== 1'b1 || fifo_free !== 5'd16) begin errors++; $display("FAIL ovf_after got %b/%0d exp 1/16", ovf_err, fifo_free); end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_midburst();
        io_axi4_rready = 1'b0;
        start_burst(4'h1, 8'd3, 1'b0);
        push_word(rand_word());
        push_word(rand_word());
        io_axi4_rready = 1'b1;
        tick();
        io_axi4_rready = 1'b0;
        checks++; if (io_axi4_rvalid !== 1'b1) begin errors++; $display("FAIL mid_pending got %b exp 1", io_axi4_rvalid); end
        #2 rstn = 1'b0;
        #1;
        checks++; if (io_axi4_rvalid !== 1'b0) begin errors++; $display("FAIL mid_rvalid got %b exp 0", io_axi4_rvalid); end
        tick();
        rstn = 1'b1;
        tick();
        checks++; if (fifo_free !== 5'd16) begin errors++; $display("FAIL mid_free got %0d exp 16", fifo_free); end
        checks++; if (rd_ready !== 1'b1) begin errors++; $display("FAIL mid_rd_ready got %b exp 1", rd_ready); end
        checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL mid_ovf got %b exp 0", ovf_err); end
        checks++; if (io_axi4_rvalid !== 1'b0) begin errors++; $display("FAIL mid_rvalid_after got %b exp 0", io_axi4_rvalid); end
        got_q.delete(); exp_q.delete(); words_q.delete();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single_upper();
        test_len2_discard();
        test_idle_buffer();
        test_latency();
        test_random();
        test_overflow();
        test_reset_midburst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
